bird_physics: RTL

BIRD_PHYSICS -- requirements
Module: bird_physics

---
 rtl/flappy_pkg.sv | 19 +
 rtl/rise_detect.sv | 26 ++
 rtl/bird_physics.sv | 139 +++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared types and default constants for the flappy-bird physics block.
package flappy_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_e;

  typedef logic signed [7:0] vel_t;

  localparam int unsigned Y_W_DEF      = 7;
  localparam int unsigned Y_MAX_DEF    = 100;
  localparam int unsigned Y_START_DEF  = 50;
  localparam int unsigned GRAVITY_DEF  = 1;
  localparam int unsigned FLAP_VEL_DEF = 6;
  localparam int unsigned V_MAX_DEF    = 8;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical physics: gravity, flap impulse, floor/ceiling handling, sticky collision.
// Optional BIRD_CEILING_KILL_EN makes a ceiling hit fatal instead of clamping.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int unsigned Y_W      = Y_W_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF,
  parameter int unsigned Y_START  = Y_START_DEF,
  parameter int unsigned GRAVITY  = GRAVITY_DEF,
  parameter int unsigned FLAP_VEL = FLAP_VEL_DEF,
  parameter int unsigned V_MAX    = V_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           flap,
  input  logic           game_enable,
  input  logic           game_reset,
  output logic [Y_W-1:0] bird_y,
  output logic [7:0]     velocity,
  output logic           collision
);

  localparam int unsigned H_W = Y_W + 2;

  localparam logic signed [8:0]     GRAV_W  = 9'(GRAVITY);
  localparam logic signed [8:0]     V_MIN_W = 9'(-int'(V_MAX));
  localparam vel_t                  FLAP_V  = 8'(FLAP_VEL);
  localparam logic signed [H_W-1:0] Y_MAX_H = H_W'(Y_MAX);

  state_e           state_q, state_d;
  logic [Y_W-1:0]   bird_y_q, bird_y_d;
  vel_t             velocity_q, velocity_d;
  logic             collision_q, collision_d;
  logic             pending_q, pending_d;

  logic             flap_pulse;
  logic signed [8:0]     vel_dec;
  vel_t                  vel_next;
  logic signed [H_W-1:0] h_next;

  rise_detect u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .in    (flap),
    .pulse (flap_pulse)
  );

  // Candidate velocity and height for a tick; widened so neither can wrap.
  always_comb begin
    vel_dec  = $signed({velocity_q[7], velocity_q}) - GRAV_W;
    if (pending_q) begin
      vel_next = FLAP_V;
    end else if (vel_dec < V_MIN_W) begin
      vel_next = 8'(V_MIN_W);
    end else begin
      vel_next = 8'(vel_dec);
    end
    h_next = $signed({2'b00, bird_y_q}) + H_W'(vel_next);
  end

  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    velocity_d  = velocity_q;
    collision_d = collision_q;
    pending_d   = pending_q;

    if (game_reset) begin
      state_d     = HOLD;
      bird_y_d    = Y_W'(Y_START);
      velocity_d  = '0;
      collision_d = 1'b0;
      pending_d   = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (game_enable) begin
            state_d = FLY;
          end
        end
        FLY: begin
          if (flap_pulse) begin
            pending_d = 1'b1;
          end
          if (tick) begin
            // A flap arriving on the tick cycle is kept for the following tick.
            pending_d  = flap_pulse;
            velocity_d = vel_next;
            bird_y_d   = h_next[Y_W-1:0];
            if (h_next[H_W-1] || (h_next == '0)) begin
              bird_y_d    = '0;
              velocity_d  = '0;
              collision_d = 1'b1;
              state_d     = DEAD;
            end else if (h_next > Y_MAX_H) begin
              bird_y_d   = Y_W'(Y_MAX);
              velocity_d = '0;
`ifdef BIRD_CEILING_KILL_EN
              collision_d = 1'b1;
              state_d     = DEAD;
`else
              collision_d = collision_q;
              state_d     = FLY;
`endif
            end
          end
        end
        DEAD: begin
          state_d = DEAD;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      bird_y_q    <= Y_W'(Y_START);
      velocity_q  <= '0;
      collision_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      velocity_q  <= velocity_d;
      collision_q <= collision_d;
      pending_q   <= pending_d;
    end
  end

  assign bird_y    = bird_y_q;
  assign velocity  = velocity_q;
  assign collision = collision_q;

endmodule
